// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped IO peripherals: window select bit,
// register offsets and the common pin-vector width.
package io_pkg;

  localparam int IO_SEL_BIT = 10;
  localparam int IO_DW      = 21;

  typedef enum logic [1:0] {
    IO_DATA   = 2'd0,
    IO_STATUS = 2'd1,
    IO_EDGES  = 2'd2,
    IO_RSVD   = 2'd3
  } io_reg_e;

endpackage

// File: rtl/io_sync_debounce.sv
// Two-flop synchroniser plus per-vector debouncer; emits a one-cycle change
// mask in the same cycle the debounced value updates.
module io_sync_debounce
  import io_pkg::*;
#(
  parameter int DW         = IO_DW,
  parameter int DEB_CYCLES = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [DW-1:0] pin_in,
  output logic [DW-1:0] stable,
  output logic [DW-1:0] chg
);

  localparam int            CW      = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [DW-1:0] s1;
  logic [DW-1:0] s;
  logic [DW-1:0] cand;
  logic [CW-1:0] cnt;
  logic          settled;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s  <= '0;
    end else begin
      s1 <= pin_in;
      s  <= s1;
    end
  end

  // The candidate must be seen unchanged for DEB_CYCLES samples after loading.
  assign settled = (s == cand) && (cnt == CNT_MAX);
  assign chg     = settled ? (cand ^ stable) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else if (s != cand) begin
      cand <= s;
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end else begin
      stable <= cand;
    end
  end

endmodule

// File: rtl/io_input_reader.sv
// Read-side IO port on the data bus: debounced pin state, sticky change flags
// with write-1-to-clear, and the 1-cycle read mux between IO and data RAM.
module io_input_reader
  import io_pkg::*;
#(
  parameter int DW         = IO_DW,
  parameter int DEB_CYCLES = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          d_rw,
  input  logic [10:0]   daddr,
  input  logic [31:0]   ddata_w,
  input  logic [31:0]   mem0_dr,
  input  logic [DW-1:0] pin_in,
  output logic [31:0]   ddata_r,
  output logic          io_irq
);

  logic [DW-1:0] stable;
  logic [DW-1:0] chg;
  logic [DW-1:0] edges;
  logic [DW-1:0] clr;
  logic          io_sel;
  logic          edges_wr;
  io_reg_e       offset;
  logic [31:0]   io_rdata;
  logic [31:0]   io_q;
  logic          sel_q;
  logic          unused_bits;

  io_sync_debounce #(
    .DW         (DW),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sync_debounce (
    .clock   (clock),
    .reset_n (reset_n),
    .pin_in  (pin_in),
    .stable  (stable),
    .chg     (chg)
  );

  assign io_sel      = daddr[IO_SEL_BIT];
  assign offset      = io_reg_e'(daddr[1:0]);
  assign edges_wr    = d_rw && io_sel && (offset == IO_EDGES);
  assign clr         = edges_wr ? ddata_w[DW-1:0] : '0;
  assign unused_bits = ^{daddr[9:2], ddata_w[31:DW]};

  // New changes are OR-ed in after the clear so a simultaneous set survives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edges <= '0;
    end else begin
      edges <= (edges & ~clr) | chg;
    end
  end

  assign io_irq = |edges;

  always_comb begin
    io_rdata = '0;
    case (offset)
      IO_DATA:   io_rdata[DW-1:0] = stable;
      IO_STATUS: io_rdata[0]      = io_irq;
      IO_EDGES:  io_rdata[DW-1:0] = edges;
      default:   io_rdata         = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_q <= 1'b0;
      io_q  <= '0;
    end else begin
      sel_q <= io_sel;
      io_q  <= io_rdata;
    end
  end

  assign ddata_r = sel_q ? io_q : mem0_dr;

endmodule
